uart_baud_gen: RTL and testbench



---
 rtl/uart_baud_gen_if.sv | 28 ++
 rtl/uart_baud_gen.sv | 125 ++++++++++++
 tb/tb_uart_baud_gen.sv | 270 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_baud_gen_if.sv
// Control and strobe bundle between a UART engine and its baud tick generator.
// The master side (UART control logic) programs the rate and restarts the
// phase; the slave side (uart_baud_gen) returns the strobes.
interface uart_baud_gen_if #(
    parameter int ACC_W = 32,
    parameter int OS    = 16
);
    localparam int CNT_W = $clog2(OS);

    logic             enable;
    logic [ACC_W-1:0] inc;
    logic             inc_load;
    logic             restart;
    logic             tick_os;
    logic             tick_bit;
    logic             tick_mid;
    logic [CNT_W-1:0] os_cnt;

    modport master (
        output enable, inc, inc_load, restart,
        input  tick_os, tick_bit, tick_mid, os_cnt
    );

    modport slave (
        input  enable, inc, inc_load, restart,
        output tick_os, tick_bit, tick_mid, os_cnt
    );
endinterface

// File: rtl/uart_baud_gen.sv
// Fractional-N (NCO) baud tick generator.
// A phase accumulator adds inc_act every enabled cycle; its carry, registered,
// is the oversample strobe. A power-of-two oversample counter derives the
// bit-boundary and bit-centre strobes. Rate changes are staged in a shadow
// register and only take effect on an interval boundary, so no interval is
// ever produced at a mixed rate. restart realigns the phase to an RX edge.
module uart_baud_gen #(
    parameter int ACC_W = 32,
    parameter int OS    = 16
) (
    input  logic           clk,
    input  logic           rst,
    uart_baud_gen_if.slave bus
);
    localparam int              CNT_W    = $clog2(OS);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(OS - 1);
    localparam logic [CNT_W-1:0] CNT_MID  = CNT_W'(OS / 2 - 1);

    // Architectural state
    logic [ACC_W-1:0] acc;
    logic [ACC_W-1:0] inc_act;
    logic [ACC_W-1:0] inc_shd;
    logic             pend;
    logic [CNT_W-1:0] os_cnt;
    logic             tick_os;

    // Next-state values
    logic [ACC_W-1:0] acc_nxt;
    logic [ACC_W-1:0] inc_act_nxt;
    logic [ACC_W-1:0] inc_shd_nxt;
    logic             pend_nxt;
    logic [CNT_W-1:0] os_cnt_nxt;
    logic             tick_os_nxt;

    // Full-width sum; the top bit is the overflow that becomes tick_os
    logic [ACC_W:0]   sum;
    logic             carry;

    assign sum   = {1'b0, acc} + {1'b0, inc_act};
    assign carry = sum[ACC_W];

    // Phase accumulator and carry capture; restart drops any carry formed this cycle
    always_comb begin
        acc_nxt     = acc;
        tick_os_nxt = 1'b0;
        if (bus.restart) begin
            acc_nxt = '0;
        end else if (bus.enable) begin
            acc_nxt     = sum[ACC_W-1:0];
            tick_os_nxt = carry;
        end
    end

    // Oversample index advances on each emitted tick, even one emitted after
    // enable fell, so the count always matches the strobes the engines saw
    always_comb begin
        os_cnt_nxt = os_cnt;
        if (bus.restart) begin
            os_cnt_nxt = '0;
        end else if (tick_os) begin
            os_cnt_nxt = os_cnt + 1'b1;   // OS is a power of two: wraps naturally
        end
    end

    // Increment staging: shadow capture, then transfer on an interval boundary
    // (carry edge), immediately while idle, or at restart
    always_comb begin
        inc_shd_nxt = inc_shd;
        inc_act_nxt = inc_act;
        pend_nxt    = pend;

        if (bus.inc_load) begin
            inc_shd_nxt = bus.inc;
        end

        if (bus.restart) begin
            // A coincident load bypasses the shadow so the first add after
            // restart already runs at the new rate
            if (bus.inc_load) begin
                inc_act_nxt = bus.inc;
            end else if (pend) begin
                inc_act_nxt = inc_shd;
            end
            pend_nxt = 1'b0;
        end else begin
            if (pend && (!bus.enable || carry)) begin
                inc_act_nxt = inc_shd;
                pend_nxt    = 1'b0;
            end
            // A load landing on a transfer edge queues behind the value just moved
            if (bus.inc_load) begin
                pend_nxt = 1'b1;
            end
        end
    end

    // State registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc     <= '0;
            inc_act <= '0;
            inc_shd <= '0;
            pend    <= 1'b0;
            os_cnt  <= '0;
            tick_os <= 1'b0;
        end else begin
            acc     <= acc_nxt;
            inc_act <= inc_act_nxt;
            inc_shd <= inc_shd_nxt;
            pend    <= pend_nxt;
            os_cnt  <= os_cnt_nxt;
            tick_os <= tick_os_nxt;
        end
    end

    // Derived strobes decode the index shown during the tick, so they are
    // cycle-coincident with tick_os and clear with reset
    always_comb begin
        bus.tick_os  = tick_os;
        bus.tick_bit = tick_os && (os_cnt == CNT_LAST);
        bus.tick_mid = tick_os && (os_cnt == CNT_MID);
        bus.os_cnt   = os_cnt;
    end

endmodule

// File: tb/tb_uart_baud_gen.sv
// Directed bench for uart_baud_gen: a table of rate vectors with hand-computed
// strobe counts and first-strobe positions, plus sequences for rate change,
// restart, enable gaps and asynchronous reset.
module tb_uart_baud_gen;
    localparam int ACC_W = 32;
    localparam int OS    = 16;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    uart_baud_gen_if #(.ACC_W(ACC_W), .OS(OS)) bus();

    uart_baud_gen #(.ACC_W(ACC_W), .OS(OS)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [31:0] inc;
        int          ncyc;
        int          n_os;
        int          n_bit;
        int          n_mid;
        int          first_os;   // cycle index after restart release, 0 = none
        int          first_mid;
        int          first_bit;
    } vec_t;

    vec_t vecs[5];

    int n_pass  = 0;
    int n_total = 0;

    task automatic check(input string name, input longint act, input longint exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Load a rate while idle and realign the phase; enable is high on return
    task automatic apply_rate(input logic [31:0] v);
        bus.enable   = 1'b0;
        bus.inc      = v;
        bus.inc_load = 1'b1;
        step();
        bus.inc_load = 1'b0;
        bus.restart  = 1'b1;
        step();
        bus.restart  = 1'b0;
        bus.enable   = 1'b1;
    endtask

    // Steps until tick_os is seen; n = -1 if the bound expires
    task automatic wait_tick(output int n);
        n = 0;
        do begin
            step();
            n++;
        end while (!bus.tick_os && n < 2000);
        if (!bus.tick_os) n = -1;
    endtask

    initial begin
        int g, ticks, held_bad, cnt0, nbits;
        longint baud_inc, err;

        //           inc            ncyc   os  bit mid  fos fmid fbit
        vecs[0] = '{32'h4000_0000,   256,  64,  4,  4,   4,  32,  64};
        vecs[1] = '{32'h8000_0000,   128,  64,  4,  4,   2,  16,  32};
        vecs[2] = '{32'h0000_0000, 10000,   0,  0,  0,   0,   0,   0};
        vecs[3] = '{32'hFFFF_FFFF,   100,  99,  6,  6,   2,   9,  17};
        vecs[4] = '{32'h3000_0000,    96,  18,  1,  1,   6,  43,  86};

        rst          = 1'b1;
        bus.enable   = 1'b0;
        bus.inc      = '0;
        bus.inc_load = 1'b0;
        bus.restart  = 1'b0;
        step();
        step();
        check("reset_tick_os", bus.tick_os, 0);
        check("reset_os_cnt", bus.os_cnt, 0);
        check("reset_bit_mid", {bus.tick_bit, bus.tick_mid}, 0);
        rst = 1'b0;

        // inc_act resets to zero: enabling without a load gives no strobes
        bus.enable = 1'b1;
        ticks = 0;
        for (int c = 0; c < 50; c++) begin
            step();
            if (bus.tick_os) ticks++;
        end
        check("no_load_silent", ticks, 0);

        // ---------------- table-driven rate vectors ----------------
        for (int v = 0; v < 5; v++) begin
            int c_os, c_bit, c_mid, fo, fm, fb, seq_bad, b2b;
            logic prev;
            c_os = 0; c_bit = 0; c_mid = 0; fo = 0; fm = 0; fb = 0;
            seq_bad = 0; b2b = 0; prev = 1'b0;
            apply_rate(vecs[v].inc);
            for (int c = 1; c <= vecs[v].ncyc; c++) begin
                step();
                if (bus.tick_os) begin
                    if (int'(bus.os_cnt) != c_os % OS) seq_bad++;
                    if (prev) b2b++;
                    if (fo == 0) fo = c;
                    c_os++;
                end
                if (bus.tick_bit) begin
                    if (!bus.tick_os) seq_bad++;
                    if (fb == 0) fb = c;
                    c_bit++;
                end
                if (bus.tick_mid) begin
                    if (!bus.tick_os) seq_bad++;
                    if (fm == 0) fm = c;
                    c_mid++;
                end
                prev = bus.tick_os;
            end
            check($sformatf("v%0d_os_count", v), c_os, vecs[v].n_os);
            check($sformatf("v%0d_bit_count", v), c_bit, vecs[v].n_bit);
            check($sformatf("v%0d_mid_count", v), c_mid, vecs[v].n_mid);
            check($sformatf("v%0d_first_os", v), fo, vecs[v].first_os);
            check($sformatf("v%0d_first_mid", v), fm, vecs[v].first_mid);
            check($sformatf("v%0d_first_bit", v), fb, vecs[v].first_bit);
            check($sformatf("v%0d_os_cnt_seq", v), seq_bad, 0);
            if (vecs[v].inc <= 32'h8000_0000)
                check($sformatf("v%0d_tick_gap", v), b2b, 0);
        end

        // ---------------- mid-stream rate change ----------------
        apply_rate(32'h4000_0000);
        wait_tick(g);
        check("midload_first", g, 4);
        bus.inc      = 32'h2000_0000;
        bus.inc_load = 1'b1;
        step();
        bus.inc_load = 1'b0;
        wait_tick(g);
        check("midload_old_gap", g + 1, 4);
        wait_tick(g);
        check("midload_new_gap", g, 8);
        wait_tick(g);
        check("midload_steady_gap", g, 8);

        // ---------------- restart two cycles before a tick ----------------
        apply_rate(32'h4000_0000);
        wait_tick(g);
        wait_tick(g);
        wait_tick(g);
        step();
        bus.restart = 1'b1;
        step();
        bus.restart = 1'b0;
        check("restart_os_cnt", bus.os_cnt, 0);
        wait_tick(g);
        check("restart_gap", g, 4);
        check("restart_tick_idx", bus.os_cnt, 0);

        // ---------------- restart coincident with inc_load ----------------
        wait_tick(g);
        bus.inc      = 32'h8000_0000;
        bus.inc_load = 1'b1;
        bus.restart  = 1'b1;
        step();
        bus.inc_load = 1'b0;
        bus.restart  = 1'b0;
        wait_tick(g);
        check("rst_load_gap", g, 2);
        check("rst_load_idx", bus.os_cnt, 0);
        wait_tick(g);
        check("rst_load_gap2", g, 2);

        // ---------------- restart while disabled ----------------
        wait_tick(g);
        wait_tick(g);
        bus.enable  = 1'b0;
        bus.restart = 1'b1;
        step();
        bus.restart = 1'b0;
        step();
        check("rst_dis_os_cnt", bus.os_cnt, 0);
        check("rst_dis_tick", bus.tick_os, 0);
        bus.enable = 1'b1;
        wait_tick(g);
        check("rst_dis_gap", g, 2);

        // ---------------- enable falls with a tick already registered ----------------
        wait_tick(g);
        cnt0 = int'(bus.os_cnt);
        bus.enable = 1'b0;
        #1;
        check("en_fall_tick_held", bus.tick_os, 1);
        step();
        check("en_fall_os_cnt", bus.os_cnt, (cnt0 + 1) % OS);
        ticks = 0;
        for (int c = 0; c < 3; c++) begin
            step();
            if (bus.tick_os) ticks++;
        end
        check("en_fall_quiet", ticks, 0);
        bus.enable = 1'b1;
        wait_tick(g);
        check("en_fall_resume_gap", g, 2);

        // ---------------- enable gap of 7 cycles shifts the schedule by 7 ----------------
        apply_rate(32'h4000_0000);
        wait_tick(g);
        wait_tick(g);
        step();
        cnt0 = int'(bus.os_cnt);
        bus.enable = 1'b0;
        ticks = 0;
        held_bad = 0;
        for (int c = 0; c < 7; c++) begin
            step();
            if (bus.tick_os) ticks++;
            if (int'(bus.os_cnt) != cnt0) held_bad++;
        end
        bus.enable = 1'b1;
        wait_tick(g);
        check("gap7_quiet", ticks, 0);
        check("gap7_os_cnt_held", held_bad, 0);
        check("gap7_interval", 1 + 7 + g, 11);

        // ---------------- 115200 baud from 124.875 MHz ----------------
        baud_inc = (64'd115200 * 64'd16 * (64'd1 << 32) + 64'd62437500) / 64'd124875000;
        apply_rate(baud_inc[31:0]);
        nbits = 0;
        for (int c = 0; c < 50000; c++) begin
            step();
            if (bus.tick_bit) nbits++;
        end
        err = longint'(nbits) * 64'd124875000 - 64'd50000 * 64'd115200;
        if (err < 0) err = -err;
        check("baud115200_bits_within_1", (err <= 64'd124875000) ? 1 : 0, 1);

        // ---------------- asynchronous reset mid-stream ----------------
        apply_rate(32'h8000_0000);
        wait_tick(g);
        wait_tick(g);
        wait_tick(g);
        #2;
        rst = 1'b1;
        #1;
        check("async_rst_tick_os", bus.tick_os, 0);
        check("async_rst_os_cnt", bus.os_cnt, 0);
        step();
        rst = 1'b0;
        ticks = 0;
        for (int c = 0; c < 20; c++) begin
            step();
            if (bus.tick_os) ticks++;
        end
        check("async_rst_inc_cleared", ticks, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
